// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channels (ALU and load) plus the registered register-file write port.
interface regfile_write_arbiter_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  logic              WriteEnable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data_in;
  logic              grant_last;

  // Requester side: drives writeback requests, observes ready and the write port
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  WriteEnable, write_address, write_data_in, grant_last
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output WriteEnable, write_address, write_data_in, grant_last
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two one-entry writeback slots (ALU = req0, load = req1)
// merged onto a single registered write port. Writes to $zero are drained silently.
// Build option: define REGFILE_ARB_ROUND_ROBIN_EN for round-robin on contention;
// otherwise the load requester (req1) always wins contention.
module regfile_write_arbiter (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  regfile_write_arbiter_if.slave  bus
);
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_REQ = 2;

  typedef struct packed {
    logic              full;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t               slot0_q, slot1_q;
  slot_t               slot0_d, slot1_d;
  slot_t               gslot_c;

  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                glast_q, glast_d;

  logic [NUM_REQ-1:0]  full_c;
  logic [NUM_REQ-1:0]  grant_c;
  logic [NUM_REQ-1:0]  ready_c;
  logic [NUM_REQ-1:0]  valid_c;
  logic [NUM_REQ-1:0]  xfer_c;

  assign full_c  = {slot1_q.full, slot0_q.full};
  assign valid_c = {bus.req1_valid, bus.req0_valid};

  // Pick at most one full slot; nothing is granted while flushing
  always_comb begin
    grant_c = '0;
    if (!flush) begin
      if (full_c == 2'b11) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        grant_c = glast_q ? 2'b01 : 2'b10;
`else
        grant_c = 2'b10;
`endif
      end else if (full_c[0]) begin
        grant_c = 2'b01;
      end else if (full_c[1]) begin
        grant_c = 2'b10;
      end
    end
  end

  // A slot accepts when empty or being drained this cycle; flush blocks everything
  assign ready_c = ~{NUM_REQ{flush}} & (~full_c | grant_c);
  assign xfer_c  = valid_c & ready_c;

  assign bus.req0_ready = ready_c[0];
  assign bus.req1_ready = ready_c[1];

  assign gslot_c = grant_c[1] ? slot1_q : slot0_q;

  // Next-state for slots, write port and grant history
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    glast_d = glast_q;

    if (flush) begin
      slot0_d.full = 1'b0;
      slot1_d.full = 1'b0;
    end else begin
      if (grant_c != '0) begin
        glast_d = grant_c[1];
        // $zero is drained without a write strobe; the port keeps its last value
        if (gslot_c.addr != ADDR_W'(0)) begin
          we_d    = 1'b1;
          waddr_d = gslot_c.addr;
          wdata_d = gslot_c.data;
        end
      end

      if (xfer_c[0]) begin
        slot0_d.full = 1'b1;
        slot0_d.addr = bus.req0_addr;
        slot0_d.data = bus.req0_data;
      end else if (grant_c[0]) begin
        slot0_d.full = 1'b0;
      end

      if (xfer_c[1]) begin
        slot1_d.full = 1'b1;
        slot1_d.addr = bus.req1_addr;
        slot1_d.data = bus.req1_data;
      end else if (grant_c[1]) begin
        slot1_d.full = 1'b0;
      end
    end
  end

  // State registers; reset leaves grant_last at 1 so req0 wins the first contention
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      glast_q <= 1'b1;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      glast_q <= glast_d;
    end
  end

  assign bus.WriteEnable   = we_q;
  assign bus.write_address = waddr_q;
  assign bus.write_data_in = wdata_q;
  assign bus.grant_last    = glast_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter with a cycle-level reference model.
module tb_regfile_write_arbiter;
  logic clock;
  logic reset;
  logic flush;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference model: what each requester has buffered and what the write port shows
  bit          m_full [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_glast;

  // Current stimulus (held across one cycle)
  bit          s_valid [2];
  logic [4:0]  s_addr  [2];
  logic [31:0] s_data  [2];
  bit          s_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) m_full[k] = 0;
    m_we = 0; m_waddr = '0; m_wdata = '0; m_glast = 1'b1;
  endfunction

  // Which buffered write goes this cycle: -1 when nothing is granted
  function automatic int model_grant();
    if (s_flush) return -1;
    if (m_full[0] && m_full[1]) begin
      if (RR) return (m_glast == 1'b1) ? 0 : 1;
      return 1;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit model_ready(input int k);
    return !s_flush && (!m_full[k] || model_grant() == k);
  endfunction

  function automatic void model_edge();
    int g;
    bit xfer [2];
    g = model_grant();
    for (int k = 0; k < 2; k++) xfer[k] = s_valid[k] && model_ready(k);
    m_we = 0;
    if (g >= 0) begin
      m_glast = g[0];
      if (m_addr[g] != 5'd0) begin
        m_we = 1; m_waddr = m_addr[g]; m_wdata = m_data[g];
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (s_flush) m_full[k] = 0;
      else if (xfer[k]) begin
        m_full[k] = 1; m_addr[k] = s_addr[k]; m_data[k] = s_data[k];
      end else if (g == k) m_full[k] = 0;
    end
  endfunction

  task automatic apply_inputs();
    bus.req0_valid = s_valid[0]; bus.req0_addr = s_addr[0]; bus.req0_data = s_data[0];
    bus.req1_valid = s_valid[1]; bus.req1_addr = s_addr[1]; bus.req1_data = s_data[1];
    flush = s_flush;
  endtask

  // One clock: drive at negedge, check ready before the edge, check registered outputs after
  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input bit fl);
    s_valid[0] = v0; s_addr[0] = a0; s_data[0] = d0;
    s_valid[1] = v1; s_addr[1] = a1; s_data[1] = d1;
    s_flush = fl;
    apply_inputs();
    #1;
    check("req0_ready", 32'(bus.req0_ready), 32'(model_ready(0)));
    check("req1_ready", 32'(bus.req1_ready), 32'(model_ready(1)));
    @(posedge clock);
    model_edge();
    #1;
    check("WriteEnable", 32'(bus.WriteEnable), 32'(m_we));
    check("write_address", 32'(bus.write_address), 32'(m_waddr));
    check("write_data_in", bus.write_data_in, m_wdata);
    check("grant_last", 32'(bus.grant_last), 32'(m_glast));
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  task automatic do_reset();
    s_valid[0] = 0; s_valid[1] = 0; s_flush = 0;
    s_addr[0] = '0; s_addr[1] = '0; s_data[0] = '0; s_data[1] = '0;
    apply_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_we", 32'(bus.WriteEnable), 32'd0);
    check("rst_waddr", 32'(bus.write_address), 32'd0);
    check("rst_wdata", bus.write_data_in, 32'd0);
    check("rst_glast", 32'(bus.grant_last), 32'd1);
    check("rst_ready0", 32'(bus.req0_ready), 32'd1);
    check("rst_ready1", 32'(bus.req1_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [4:0]  seq [4];
  logic [4:0]  exp_a;
  logic [31:0] exp_first, exp_second;

  initial begin
    reset = 1'b0;
    s_flush = 0;
    for (int k = 0; k < 2; k++) begin s_valid[k] = 0; s_addr[k] = '0; s_data[k] = '0; end
    apply_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    do_reset();

    // Lone ALU write: slot fills on the transfer edge, strobe one edge later, then drops
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0);
    check("lat_we_fill", 32'(bus.WriteEnable), 32'd0);
    idle();
    check("lat_we", 32'(bus.WriteEnable), 32'd1);
    check("lat_addr", 32'(bus.write_address), 32'd5);
    check("lat_data", bus.write_data_in, 32'hDEADBEEF);
    idle();
    check("lat_we_drop", 32'(bus.WriteEnable), 32'd0);
    check("lat_addr_hold", 32'(bus.write_address), 32'd5);

    // Lone requester streams one write per cycle
    for (int i = 0; i < 4; i++) step(0, 5'd0, 32'd0, 1, 5'(8 + i), 32'(100 + i), 0);
    check("stream_we", 32'(bus.WriteEnable), 32'd1);
    check("stream_addr", 32'(bus.write_address), 32'd10);
    idle();
    idle();

    // Continuous contention on addresses 3 and 4
    do_reset();
    step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0);
      seq[i] = bus.write_address;
      check("cont_we", 32'(bus.WriteEnable), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      if (RR) exp_a = (i % 2 == 0) ? 5'd3 : 5'd4;
      else    exp_a = 5'd4;
      check("cont_seq", 32'(seq[i]), 32'(exp_a));
    end
    repeat (3) idle();

    // Same destination in both slots: grant order decides which value lands last
    do_reset();
    step(1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 0);
    exp_first  = RR ? 32'h11111111 : 32'h22222222;
    exp_second = RR ? 32'h22222222 : 32'h11111111;
    idle();
    check("same_first", bus.write_data_in, exp_first);
    idle();
    check("same_second", bus.write_data_in, exp_second);
    check("same_addr", 32'(bus.write_address), 32'd7);
    idle();

    // $zero destination drains without a strobe
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 0);
    idle();
    check("zero_we", 32'(bus.WriteEnable), 32'd0);
    check("zero_ready1", 32'(bus.req1_ready), 32'd1);
    check("zero_hold", bus.write_data_in, exp_second);
    idle();

    // Flush with both slots full discards both buffered writes
    step(1, 5'd12, 32'hAAAA, 1, 5'd13, 32'hBBBB, 0);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    check("flush_we", 32'(bus.WriteEnable), 32'd0);
    idle();
    check("flush_after_we", 32'(bus.WriteEnable), 32'd0);
    check("flush_after_ready0", 32'(bus.req0_ready), 32'd1);
    check("flush_after_ready1", 32'(bus.req1_ready), 32'd1);
    idle();
    check("flush_never_we", 32'(bus.WriteEnable), 32'd0);

    // Asynchronous reset mid-cycle with both slots full and a write on the port
    step(1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 0);
    step(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0);
    check("pre_arst_we", 32'(bus.WriteEnable), 32'd1);
    s_valid[0] = 0; s_valid[1] = 0;
    apply_inputs();
    #2;
    reset = 1'b0;
    #1;
    check("arst_we", 32'(bus.WriteEnable), 32'd0);
    check("arst_waddr", 32'(bus.write_address), 32'd0);
    check("arst_ready0", 32'(bus.req0_ready), 32'd1);
    check("arst_ready1", 32'(bus.req1_ready), 32'd1);
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic, including $zero destinations and occasional flushes
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 19) == 0);
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
